// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional two's-complement mode is selected with the SEQ_DIVIDER_SIGNED_EN macro.
package div_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        CHECK  = 3'd2,
        DIVIDE = 3'd3,
        FIXUP  = 3'd4,
        PUT_Z  = 3'd5
    } state_t;

    // Quotient reported on divide-by-zero; sliced to the operand width at use.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    // Partial remainder is always below the divisor, so bit WIDTH of diff is a clean borrow.
    assign q_o     = ~diff[WIDTH];
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider with stb/ack handshakes on both operands and the result.
// SEQ_DIVIDER_SIGNED_EN selects two's-complement operands; default build is unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic [WIDTH-1:0] output_r,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic             output_dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               a_ack_q;
    logic               b_ack_q;
    logic               z_stb_q;
    logic [WIDTH-1:0]   z_q;
    logic [WIDTH-1:0]   r_q;
    logic               dz_q;

    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH-1:0]   step_rem_d;
    logic               step_q_d;
    logic [WIDTH-1:0]   fix_z_d;
    logic [WIDTH-1:0]   fix_r_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_z_q;
    logic neg_r_q;

    assign mag_a_d = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b_d = b_q[WIDTH-1] ? -b_q : b_q;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign fix_z_d = neg_z_q ? -quo_q : quo_q;
    assign fix_r_d = neg_r_q ? -rem_q : rem_q;
`else
    assign mag_a_d = a_q;
    assign mag_b_d = b_q;
    assign fix_z_d = quo_q;
    assign fix_r_d = rem_q;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (b_q),
        .rem_o     (step_rem_d),
        .q_o       (step_q_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            z_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_z_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                GET_A: begin
                    if (a_ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        a_ack_q <= 1'b0;
                        b_ack_q <= 1'b1;
                        state_q <= GET_B;
                    end else begin
                        a_ack_q <= 1'b1;
                    end
                end
                GET_B: begin
                    if (b_ack_q && input_b_stb) begin
                        b_q     <= input_b;
                        b_ack_q <= 1'b0;
                        state_q <= CHECK;
                    end else begin
                        b_ack_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (b_q == '0) begin
                        z_q     <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        r_q     <= a_q;
                        dz_q    <= 1'b1;
                        z_stb_q <= 1'b1;
                        state_q <= PUT_Z;
                    end else begin
                        quo_q   <= mag_a_d;
                        b_q     <= mag_b_d;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_z_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        neg_r_q <= a_q[WIDTH-1];
`endif
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    // Dividend bits shift out of quo_q as quotient bits shift in.
                    rem_q <= step_rem_d;
                    quo_q <= {quo_q[WIDTH-2:0], step_q_d};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    z_q     <= fix_z_d;
                    r_q     <= fix_r_d;
                    dz_q    <= 1'b0;
                    z_stb_q <= 1'b1;
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    if (z_stb_q && output_z_ack) begin
                        z_stb_q <= 1'b0;
                        a_ack_q <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                default: begin
                    state_q <= GET_A;
                end
            endcase
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z_stb = z_stb_q;
    assign output_z     = z_q;
    assign output_r     = r_q;
    assign output_dz    = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus reset, stall and back-pressure sequences.
module tb_seq_divider;

    localparam int W = 32;
    localparam int LAT_NZ = W + 2;
    localparam int LAT_Z  = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] input_a = '0;
    logic         input_a_stb = 1'b0;
    logic         input_a_ack;
    logic [W-1:0] input_b = '0;
    logic         input_b_stb = 1'b0;
    logic         input_b_ack;
    logic [W-1:0] output_z;
    logic [W-1:0] output_r;
    logic         output_z_stb;
    logic         output_z_ack = 1'b0;
    logic         output_dz;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_r     (output_r),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .output_dz    (output_dz)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents A then B; returns just after the B-accept edge.
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        int n;
        ok = 1'b0;
        @(negedge clk);
        input_a = a;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!input_a_ack) begin
            chk("a_ack_timeout", 32'd0, 32'd1);
            input_a_stb = 1'b0;
            return;
        end
        @(negedge clk);
        input_a_stb = 1'b0;
        chk("a_ack_drop", {31'd0, input_a_ack}, 32'd0);
        input_b = b;
        input_b_stb = 1'b1;
        n = 0;
        while (!input_b_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!input_b_ack) begin
            chk("b_ack_timeout", 32'd0, 32'd1);
            input_b_stb = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        input_b_stb = 1'b0;
        chk("b_ack_drop", {31'd0, input_b_ack}, 32'd0);
        ok = 1'b1;
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                           output logic [W-1:0] z, output logic [W-1:0] r,
                           output logic dz, output int lat);
        bit ok;
        bit unstable;
        z = '0;
        r = '0;
        dz = 1'b0;
        lat = -1;
        feed(a, b, ok);
        if (!ok) return;
        lat = 0;
        while (!output_z_stb && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!output_z_stb) begin
            chk("z_stb_timeout", 32'd0, 32'd1);
            return;
        end
        z = output_z;
        r = output_r;
        dz = output_dz;
        unstable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!output_z_stb || output_z !== z || output_r !== r || output_dz !== dz)
                unstable = 1'b1;
        end
        if (hold > 0) chk("hold_stable", {31'd0, unstable}, 32'd0);
        @(negedge clk);
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
        chk("z_stb_drop", {31'd0, output_z_stb}, 32'd0);
        chk("a_ack_reassert", {31'd0, input_a_ack}, 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        logic [W-1:0] z, r;
        logic         dz;
        int           lat;
        bit           ok;
        bit           bad;

`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[3] = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
        vecs[4] = '{32'hFFFFFFC9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFC9,  1'b1};
        vecs[5] = '{32'd55,        32'd0,         32'hFFFFFFFF,  32'd55,        1'b1};
        vecs[6] = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
        vecs[7] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
`else
        vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1] = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
        vecs[2] = '{32'd55,        32'd0,         32'hFFFFFFFF,  32'd55,        1'b1};
        vecs[3] = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[4] = '{32'd7,         32'd100,       32'd0,         32'd7,         1'b0};
        vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b0};
        vecs[6] = '{32'h80000000,  32'd3,         32'd715827882, 32'd2,         1'b0};
        vecs[7] = '{32'd1000000,   32'd1000,      32'd1000,      32'd0,         1'b0};
`endif

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        chk("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        chk("rst_z", output_z, 32'd0);
        chk("rst_r", output_r, 32'd0);
        chk("rst_dz", {31'd0, output_dz}, 32'd0);
        rst = 1'b0;

        // Stall in GET_A with B strobing: nothing may be accepted.
        input_b = 32'd9;
        input_b_stb = 1'b1;
        bad = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!input_a_ack || input_b_ack || output_z_stb) bad = 1'b1;
        end
        input_b_stb = 1'b0;
        chk("stall_get_a", {31'd0, bad}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_div(vecs[i].a, vecs[i].b, 0, z, r, dz, lat);
            chk($sformatf("v%0d_z", i), z, vecs[i].z);
            chk($sformatf("v%0d_r", i), r, vecs[i].r);
            chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].dz ? LAT_Z : LAT_NZ);
            $display("[TB] vec %0d: a=0x%08h b=0x%08h -> z=0x%08h r=0x%08h dz=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, z, r, dz, lat);
        end

        // Reset pulsed ten cycles into DIVIDE.
        feed(32'd1000, 32'd3, ok);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_a_ack", {31'd0, input_a_ack}, 32'd0);
        chk("midrst_b_ack", {31'd0, input_b_ack}, 32'd0);
        chk("midrst_z_stb", {31'd0, output_z_stb}, 32'd0);
        chk("midrst_z", output_z, 32'd0);
        chk("midrst_r", output_r, 32'd0);
        chk("midrst_dz", {31'd0, output_dz}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_get_a", {31'd0, input_a_ack}, 32'd1);
        run_div(32'd20, 32'd3, 0, z, r, dz, lat);
        chk("after_rst_z", z, 32'd6);
        chk("after_rst_r", r, 32'd2);
        chk("after_rst_lat", lat, LAT_NZ);
        $display("[TB] post-reset 20/3 -> z=%0d r=%0d lat=%0d", z, r, lat);

        // Result held under back-pressure for 50 cycles.
        run_div(32'd12345, 32'd67, 50, z, r, dz, lat);
        chk("hold_z", z, 32'd184);
        chk("hold_r", r, 32'd17);
        chk("hold_dz", {31'd0, dz}, 32'd0);
        $display("[TB] held 12345/67 -> z=%0d r=%0d", z, r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 input_a  input  WIDTH  dividend.
REQ-005 input_a_stb  input  1  dividend valid.
REQ-006 input_a_ack  output  1  dividend accepted.
REQ-007 input_b  input  WIDTH  divisor.
REQ-008 input_b_stb  input  1  divisor valid.
REQ-009 input_b_ack  output  1  divisor accepted.
REQ-010 output_z  output  WIDTH  quotient.
REQ-011 output_r  output  WIDTH  remainder.
REQ-012 output_z_stb  output  1  quotient/remainder valid.
REQ-013 output_z_ack  input  1  consumer has taken the result.
REQ-014 output_dz  output  1  divide-by-zero flag, valid with output_z_stb.

Function
REQ-015 The FSM SHALL have states GET_A, GET_B, CHECK, DIVIDE, FIXUP, PUT_Z.
REQ-016 GET_A: input_a_ack=1; on input_a_stb&&input_a_ack, latch input_a, ack drops next cycle, go GET_B.
REQ-017 GET_B: input_b_ack=1; on input_b_stb&&input_b_ack, latch input_b, go CHECK.
REQ-018 Ack SHALL be a registered output, high for exactly one cycle per transfer when stb is already high.
REQ-019 CHECK: divisor==0 -> quotient all-ones, remainder = dividend, output_dz=1, go PUT_Z; else load iteration counter = WIDTH, go DIVIDE.
REQ-020 DIVIDE: one restoring shift-subtract step per cycle, exactly WIDTH cycles, then FIXUP.
REQ-021 FIXUP: one cycle; applies sign correction (signed build) or passes through; go PUT_Z.
REQ-022 PUT_Z: output_z_stb=1, outputs stable; on output_z_stb&&output_z_ack, stb drops next cycle, go GET_A.
REQ-023 Latency, B-accept edge to output_z_stb rising: WIDTH+2 cycles nonzero divisor, 1 cycle zero divisor.
REQ-024 Results SHALL satisfy a == z*b + r, 0 <= r < b (unsigned).
REQ-025 Stb held low in GET_A/GET_B SHALL stall indefinitely with no state change.
REQ-026 input_b_stb asserted during GET_A SHALL be ignored (A always first).
REQ-027 output_z_ack low in PUT_Z SHALL hold results indefinitely.

Reset
REQ-028 rst during any state SHALL return FSM to GET_A on the next edge, abandoning any division in progress.
REQ-029 Reset values: input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0, output_r=0, output_dz=0.

Configuration
REQ-030 Macro SEQ_DIVIDER_SIGNED_EN defined: operands two's complement; quotient truncates toward zero; remainder takes dividend sign; MIN/-1 -> z=MIN, r=0, output_dz=0; divide-by-zero -> z=all-ones, r=dividend.
REQ-031 Macro undefined: operands unsigned; FIXUP is pass-through; no sign logic synthesised.

Structure
REQ-032 Shared package div_pkg SHALL hold the FSM state enum typedef and the divide-by-zero quotient constant.
REQ-033 One combinational sub-module div_step SHALL implement a single restoring iteration (partial remainder, next quotient bit); seq_divider instantiates it once.

Verification
REQ-034 a=100, b=7 unsigned -> z=14, r=2, dz=0, stb 34 cycles after B accept.
REQ-035 a=0xFFFFFFFF, b=1 -> z=0xFFFFFFFF, r=0.
REQ-036 b=0, a=55 -> z=0xFFFFFFFF, r=55, dz=1, stb 1 cycle after B accept.
REQ-037 Signed build: a=-7, b=2 -> z=-3, r=-1; a=0x80000000, b=-1 -> z=0x80000000, r=0.
REQ-038 rst pulsed mid-DIVIDE (cycle 10) -> next cycle GET_A, all outputs at reset values; a following 20/3 -> z=6, r=2.
REQ-039 output_z_ack held low 50 cycles -> stb and outputs stable; ack then high -> stb low next cycle, input_a_ack reasserts.
